reg_bank_ctrl: RTL and testbench
================================

# reg_bank_ctrl

Sequencer and two-port round-robin arbiter for a bank of `reg_16_bit` storage registers. It shares the bank between two requesters, port 0 (ALU writeback) and port 1 (memory load/store path). It drives the bank's shared write-data bus and its one-hot write and read strobes, and captures the shared tri-state read bus. Each requester sees a simple req/ack transaction interface and never touches the strobes directly.

## Interface
- `NUM_REGS`, default 8: number of `reg_16_bit` instances in the bank; legal range 2..16.
- `ADDR_W`, default 3: register address width; must satisfy 2^ADDR_W >= NUM_REGS.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0` / `req1`  in  1  transaction request from port 0 / port 1.
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  ADDR_W  target register index.
- `wdata0` / `wdata1`  in  16  write data.
- `ack0` / `ack1`  out  1  one-cycle completion pulse.
- `rdata0` / `rdata1`  out  16  read result; held until that port's next read completes.
- `bus_a`  out  16  write data to the `A` input of every bank register.
- `bus_b`  in  16  shared read bus from the `B` outputs; Z/X when no `read` strobe is active.
- `reg_write`  out  NUM_REGS  one-hot per-register `write` strobes.
- `reg_read`  out  NUM_REGS  one-hot per-register `read` strobes.
- `busy`  out  1  high whenever state ≠ IDLE.
- `err`  out  1  one-cycle pulse, coincident with ack, for an out-of-range address.

## Operation
- States:
  - IDLE: sample requests.
  - WR: drive `bus_a`, `reg_write[addr]` = 1.
  - RD: `reg_read[addr]` = 1, bus settles.
  - CAP: `reg_read[addr]` still 1; latch `bus_b`.
  - ACK: pulse the winner's ack.
- Transitions: IDLE→WR (accepted write), IDLE→RD (accepted read), WR→ACK, RD→CAP, CAP→ACK, ACK→IDLE.
- Arbitration happens only in IDLE.
  - One req high: that port wins.
  - Both high: the port not served last wins.
  - The last-served pointer updates on accept. Reset value makes port 0 win the first contention.
- On accept, the winner's `we`, `addr` and `wdata` are registered. The requester need not hold them after accept.
- Requests are ignored outside IDLE. A req dropped mid-transaction does not abort it. The loser's req stays pending and is re-arbitrated in the next IDLE.
- At most one bit of `reg_write | reg_read` is high in any cycle. Write and read strobes are never high in the same cycle.
- `bus_a` holds the registered wdata during WR and is 0 in all other states.
- Out-of-range address (addr >= NUM_REGS):
  - The normal state sequence still runs, but no strobe is asserted.
  - For a read, rdata is loaded with 0.
  - `err` pulses with ack.
- `rdataN` changes only on the CAP→ACK edge of a read served for port N. It is unaffected by writes and by the other port.
- No transformation of data: 16-bit pass-through, no sign or width handling.

## Timing
- Reset values: state IDLE; all of `ack*`, `err`, `busy`, `reg_write` and `reg_read` = 0; `bus_a` = 0; `rdata0` = `rdata1` = 0; pointer = "port 1 last".
- Write accepted at edge k:
  - WR occupies cycle k..k+1.
  - Data enters the register at edge k+1.
  - ack is high in cycle k+1..k+2.
  - IDLE again at k+2.
- Read accepted at edge k:
  - RD in cycle k..k+1, CAP in cycle k+1..k+2.
  - `bus_b` is sampled at edge k+2.
  - ack and the new rdata are visible from k+2; ack drops at k+3.
- Throughput: 3 cycles per write, 4 per read, including the IDLE cycle.
- Handshake: a registered requester that sees ack = 1 at an edge deasserts req from that edge. A req still high in the following IDLE is a new transaction.
- Reset asserted in any state:
  - The next edge forces every reset value.
  - An in-flight write whose WR cycle already passed has completed. Otherwise the register is unchanged.
  - No ack is issued for the aborted transaction.

## Test plan
- Reset, then a port 0 write of 0xFFF6 to r3, then a port 0 read of r3:
  - `reg_write` = 0x08 for exactly one cycle.
  - ack0 arrives 2 cycles after accept.
  - `rdata0` = 0xFFF6 with ack0, 3 cycles after the read is accepted.
- Both ports request in the same IDLE cycle: port 0 writes r1 = 0x1234, port 1 writes r2 = 0xABCD.
  - Port 0 is served first, then port 1.
  - On a repeat of the same contention, port 1 is served first.
  - Read-back returns 0x1234 and 0xABCD.
- Port 1 reads r5 while port 0's req is high: `rdata0` is unchanged, `reg_read` = 0x20 for exactly 2 cycles, and no write strobe is high during them.
- Port 0 writes addr 7 with NUM_REGS = 6 and data 0x5555:
  - No strobe is asserted.
  - ack0 and err pulse together.
  - A read of addr 7 returns 0 with err.
- Reset is asserted during CAP of a read:
  - Next cycle, all outputs are at their reset values and no ack is issued.
  - The next read of the same register after reset returns its prior contents.
- Port 0 deasserts req in the middle of WR: the transaction still completes and ack0 pulses.

Source files
------------

// File: rtl/reg_bank_ctrl.sv
// Sequencer and two-port round-robin arbiter for a bank of reg_16_bit registers.
// Drives the shared write bus and one-hot strobes and captures the shared read bus.
module reg_bank_ctrl #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0,
    input  logic                req1,
    input  logic                we0,
    input  logic                we1,
    input  logic [ADDR_W-1:0]   addr0,
    input  logic [ADDR_W-1:0]   addr1,
    input  logic [15:0]         wdata0,
    input  logic [15:0]         wdata1,
    output logic                ack0,
    output logic                ack1,
    output logic [15:0]         rdata0,
    output logic [15:0]         rdata1,
    output logic [15:0]         bus_a,
    input  logic [15:0]         bus_b,
    output logic [NUM_REGS-1:0] reg_write,
    output logic [NUM_REGS-1:0] reg_read,
    output logic                busy,
    output logic                err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_CAP,
        S_ACK
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_port;
    logic                r_last1;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_wdata;
    logic [15:0]         r_rdata0;
    logic [15:0]         r_rdata1;

    logic                w_accept;
    logic                w_pick1;
    logic                w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [15:0]         w_wdata;
    logic                w_inRange;
    logic [15:0]         w_capData;
    logic [NUM_REGS-1:0] w_onehot;

    // Under contention the port that was not served last wins; r_last1 = 1 favours port 0.
    assign w_accept  = (r_state == S_IDLE) && (req0 || req1);
    assign w_pick1   = req1 && (!req0 || !r_last1);
    assign w_we      = w_pick1 ? we1    : we0;
    assign w_addr    = w_pick1 ? addr1  : addr0;
    assign w_wdata   = w_pick1 ? wdata1 : wdata0;
    assign w_inRange = (32'(r_addr) < 32'(NUM_REGS));
    assign w_capData = w_inRange ? bus_b : 16'h0000;

    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_onehot[i] = (32'(r_addr) == 32'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_port   <= 1'b0;
            r_last1  <= 1'b1;
            r_addr   <= '0;
            r_wdata  <= 16'h0000;
            r_rdata0 <= 16'h0000;
            r_rdata1 <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_port  <= w_pick1;
                r_last1 <= w_pick1;
                r_addr  <= w_addr;
                r_wdata <= w_wdata;
            end
            // Read data lands on the CAP->ACK edge, only in the served port's register.
            if (r_state == S_CAP) begin
                if (r_port) begin
                    r_rdata1 <= w_capData;
                end else begin
                    r_rdata0 <= w_capData;
                end
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        reg_write = '0;
        reg_read  = '0;
        bus_a     = 16'h0000;
        ack0      = 1'b0;
        ack1      = 1'b0;
        err       = 1'b0;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_we ? S_WR : S_RD;
                end
            end
            S_WR: begin
                bus_a  = r_wdata;
                if (w_inRange) begin
                    reg_write = w_onehot;
                end
                w_next = S_ACK;
            end
            S_RD: begin
                if (w_inRange) begin
                    reg_read = w_onehot;
                end
                w_next = S_CAP;
            end
            S_CAP: begin
                if (w_inRange) begin
                    reg_read = w_onehot;
                end
                w_next = S_ACK;
            end
            S_ACK: begin
                ack0   = !r_port;
                ack1   = r_port;
                err    = !w_inRange;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Scoreboard bench for reg_bank_ctrl driving a behavioural six-register bank.
// Expected acks are queued by the stimulus and checked by an independent monitor.
module tb_reg_bank_ctrl;

    localparam int NUM_REGS = 6;
    localparam int ADDR_W   = 3;

    logic                clk;
    logic                reset;
    logic                req0, req1, we0, we1;
    logic [ADDR_W-1:0]   addr0, addr1;
    logic [15:0]         wdata0, wdata1;
    logic                ack0, ack1;
    logic [15:0]         rdata0, rdata1;
    logic [15:0]         bus_a;
    logic [15:0]         bus_b;
    logic [NUM_REGS-1:0] reg_write, reg_read;
    logic                busy, err;

    reg_bank_ctrl #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .bus_a(bus_a), .bus_b(bus_b),
        .reg_write(reg_write), .reg_read(reg_read),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register bank: strobed capture from bus_a, junk on bus_b when undriven.
    logic [15:0] bank [NUM_REGS] = '{default: 16'h0000};

    always @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_write[i]) bank[i] <= bus_a;
        end
    end

    always_comb begin
        bus_b = 16'hDEAD;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_read[i]) bus_b = bank[i];
        end
    end

    typedef struct {
        logic        port;
        logic        isRead;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t expQ[$];
    exp_t e;
    int checks = 0;
    int errors = 0;
    int wrRun = 0;
    int rdRun = 0;
    int strobeCycles = 0;
    logic [NUM_REGS-1:0] lastWr = '0;
    logic [NUM_REGS-1:0] lastRd = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushExp(input logic p, input logic isRd, input logic [15:0] d, input logic er);
        exp_t x;
        x.port = p; x.isRead = isRd; x.data = d; x.err = er;
        expQ.push_back(x);
    endtask

    // Monitor: strobe invariants, strobe run lengths and scoreboard pops on every ack.
    always @(negedge clk) begin
        checkOutput("strobe_onehot", 32'($countones(reg_write | reg_read) <= 1), 32'd1);
        if (|(reg_write | reg_read)) strobeCycles++;
        if (reg_write != '0) begin
            wrRun++;
            lastWr = reg_write;
        end else if (wrRun != 0) begin
            checkOutput("write_strobe_len", 32'(wrRun), 32'd1);
            wrRun = 0;
        end
        if (reg_read != '0) begin
            rdRun++;
            lastRd = reg_read;
        end else if (rdRun != 0) begin
            checkOutput("read_strobe_len", 32'(rdRun), 32'd2);
            rdRun = 0;
        end
        if (ack0 || ack1) begin
            checkOutput("single_ack", 32'(ack0 & ack1), 32'd0);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("ack_port", 32'(ack1), 32'(e.port));
                checkOutput("err_with_ack", 32'(err), 32'(e.err));
                if (e.isRead) checkOutput("rdata", 32'(e.port ? rdata1 : rdata0), 32'(e.data));
            end
        end else begin
            checkOutput("err_without_ack", 32'(err), 32'd0);
        end
    end

    task automatic setReq(input logic p, input logic v, input logic we, input logic [ADDR_W-1:0] a, input logic [15:0] d);
        if (p) begin
            req1 = v; we1 = we; addr1 = a; wdata1 = d;
        end else begin
            req0 = v; we0 = we; addr0 = a; wdata0 = d;
        end
    endtask

    // Registered requester: hold req until ack is seen, then drop it and scramble inputs.
    task automatic applyStimulus(input logic p, input logic we, input logic [ADDR_W-1:0] a,
                                 input logic [15:0] d, input int expLat);
        int  n;
        bit  got;
        @(negedge clk);
        setReq(p, 1'b1, we, a, d);
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (p ? ack1 : ack0) got = 1'b1;
        end
        checkOutput(p ? "ack1_seen" : "ack0_seen", 32'(got), 32'd1);
        if (got && expLat > 0) checkOutput("ack_latency", 32'(n), 32'(expLat));
        @(posedge clk);
        #1;
        setReq(p, 1'b0, 1'b0, '0, 16'h0BAD);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ack0"},  32'(ack0), 32'd0);
        checkOutput({tag, "_ack1"},  32'(ack1), 32'd0);
        checkOutput({tag, "_err"},   32'(err), 32'd0);
        checkOutput({tag, "_busy"},  32'(busy), 32'd0);
        checkOutput({tag, "_wr"},    32'(reg_write), 32'd0);
        checkOutput({tag, "_rd"},    32'(reg_read), 32'd0);
        checkOutput({tag, "_bus_a"}, 32'(bus_a), 32'd0);
        checkOutput({tag, "_rdata0"}, 32'(rdata0), 32'd0);
        checkOutput({tag, "_rdata1"}, 32'(rdata1), 32'd0);
    endtask

    int sc;
    bit gotAck;
    int waitN;

    initial begin
        reset = 1'b1;
        setReq(1'b0, 1'b0, 1'b0, '0, 16'h0);
        setReq(1'b1, 1'b0, 1'b0, '0, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetValues("por");
        reset = 1'b0;

        // Single-port write then read of r3.
        pushExp(1'b0, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'd3, 16'hFFF6, 2);
        checkOutput("t1_write_strobe", 32'(lastWr), 32'h08);
        pushExp(1'b0, 1'b1, 16'hFFF6, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd3, 16'h0000, 3);
        checkOutput("t1_read_strobe", 32'(lastRd), 32'h08);

        // Reset restores the pointer so port 0 takes the first contention.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        pushExp(1'b0, 1'b0, 16'h0000, 1'b0);
        pushExp(1'b1, 1'b0, 16'h0000, 1'b0);
        fork
            applyStimulus(1'b0, 1'b1, 3'd1, 16'h1234, 0);
            applyStimulus(1'b1, 1'b1, 3'd2, 16'hABCD, 0);
        join
        pushExp(1'b0, 1'b1, 16'h1234, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd1, 16'h0000, 3);
        // Port 0 was served last, so port 1 wins this contention.
        pushExp(1'b1, 1'b0, 16'h0000, 1'b0);
        pushExp(1'b0, 1'b0, 16'h0000, 1'b0);
        fork
            applyStimulus(1'b0, 1'b1, 3'd1, 16'h1234, 0);
            applyStimulus(1'b1, 1'b1, 3'd2, 16'hABCD, 0);
        join
        pushExp(1'b1, 1'b1, 16'hABCD, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'd2, 16'h0000, 3);

        // Port 1 reads r5 while port 0 waits with a write.
        pushExp(1'b1, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'd5, 16'h0F0F, 2);
        pushExp(1'b0, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'd0, 16'h1111, 2);
        pushExp(1'b1, 1'b1, 16'h0F0F, 1'b0);
        pushExp(1'b0, 1'b0, 16'h0000, 1'b0);
        fork
            applyStimulus(1'b1, 1'b0, 3'd5, 16'h0000, 0);
            applyStimulus(1'b0, 1'b1, 3'd4, 16'h2222, 0);
        join
        checkOutput("t3_read_strobe", 32'(lastRd), 32'h20);
        checkOutput("t3_rdata0_held", 32'(rdata0), 32'h1234);

        // Out-of-range address 7 on a six-register bank.
        sc = strobeCycles;
        pushExp(1'b0, 1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 1'b1, 3'd7, 16'h5555, 2);
        pushExp(1'b0, 1'b1, 16'h0000, 1'b1);
        applyStimulus(1'b0, 1'b0, 3'd7, 16'h0000, 3);
        checkOutput("t4_no_strobe", 32'(strobeCycles - sc), 32'd0);

        // Reset lands during CAP of a port 1 read of r3.
        @(negedge clk);
        setReq(1'b1, 1'b1, 1'b0, 3'd3, 16'h0000);
        @(posedge clk);
        #1;
        setReq(1'b1, 1'b0, 1'b0, '0, 16'h0BAD);
        @(posedge clk);
        @(negedge clk);
        checkOutput("t5_cap_strobe", 32'(reg_read), 32'h08);
        reset = 1'b1;
        @(negedge clk);
        checkResetValues("t5");
        reset = 1'b0;
        pushExp(1'b1, 1'b1, 16'hFFF6, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'd3, 16'h0000, 3);

        // Port 0 drops req and scrambles wdata in the middle of WR.
        pushExp(1'b0, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        setReq(1'b0, 1'b1, 1'b1, 3'd4, 16'h7777);
        @(posedge clk);
        @(negedge clk);
        checkOutput("t6_in_wr", 32'(reg_write), 32'h10);
        setReq(1'b0, 1'b0, 1'b0, '0, 16'h0BAD);
        gotAck = 1'b0;
        waitN = 0;
        while (!gotAck && waitN < 10) begin
            @(negedge clk);
            waitN++;
            if (ack0) gotAck = 1'b1;
        end
        checkOutput("t6_ack0_seen", 32'(gotAck), 32'd1);
        pushExp(1'b0, 1'b1, 16'h7777, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd4, 16'h0000, 3);

        repeat (3) @(negedge clk);
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
